// File: rtl/sprite_move_ctrl.sv
// Sprite motion sequencer: draw -> wait N frames -> erase -> move -> redraw, driving the box counter.
// Optional macro SPRITE_WRAP_EN: origin wraps at the screen edges instead of clamping.
module sprite_move_ctrl #(
    parameter logic [8:0] X_START         = 9'd0,
    parameter logic [7:0] Y_START         = 8'd0,
    parameter logic [8:0] X_MAX_POS       = 9'd312,
    parameter logic [7:0] Y_MAX_POS       = 8'd232,
    parameter int         FRAMES_PER_STEP = 4,
    parameter logic [2:0] FG_COLOUR       = 3'b111,
    parameter logic [2:0] BG_COLOUR       = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       go,
    input  logic       frame_tick,
    input  logic       dir_left,
    input  logic       dir_right,
    input  logic       dir_up,
    input  logic       dir_down,
    input  logic       cnt_done,
    output logic       cnt_enable,
    output logic [8:0] x_org,
    output logic [7:0] y_org,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, UPDATE} state_t;

    state_t            state;
    logic [FW-1:0]     frame_cnt;
    logic              armed;
    logic signed [9:0] x_sum;
    logic signed [8:0] y_sum;
    logic [8:0]        x_next;
    logic [7:0]        y_next;

    // Next origin from the direction inputs; only consumed in UPDATE.
    always_comb begin
        x_sum = $signed({1'b0, x_org});
        if (dir_right && !dir_left)
            x_sum = x_sum + 10'sd1;
        else if (dir_left && !dir_right)
            x_sum = x_sum - 10'sd1;

        y_sum = $signed({1'b0, y_org});
        if (dir_down && !dir_up)
            y_sum = y_sum + 9'sd1;
        else if (dir_up && !dir_down)
            y_sum = y_sum - 9'sd1;

`ifdef SPRITE_WRAP_EN
        if (x_sum < 10'sd0)
            x_next = X_MAX_POS;
        else if (x_sum > $signed({1'b0, X_MAX_POS}))
            x_next = 9'd0;
        else
            x_next = x_sum[8:0];

        if (y_sum < 9'sd0)
            y_next = Y_MAX_POS;
        else if (y_sum > $signed({1'b0, Y_MAX_POS}))
            y_next = 8'd0;
        else
            y_next = y_sum[7:0];
`else
        if (x_sum < 10'sd0)
            x_next = 9'd0;
        else if (x_sum > $signed({1'b0, X_MAX_POS}))
            x_next = X_MAX_POS;
        else
            x_next = x_sum[8:0];

        if (y_sum < 9'sd0)
            y_next = 8'd0;
        else if (y_sum > $signed({1'b0, Y_MAX_POS}))
            y_next = Y_MAX_POS;
        else
            y_next = y_sum[7:0];
`endif
    end

    // armed blocks the counter's stale done during the first enabled cycle of a box.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            x_org      <= X_START;
            y_org      <= Y_START;
            frame_cnt  <= '0;
            armed      <= 1'b0;
            cnt_enable <= 1'b0;
            plot       <= 1'b0;
            colour     <= BG_COLOUR;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state      <= DRAW;
                        cnt_enable <= 1'b1;
                        plot       <= 1'b1;
                        colour     <= FG_COLOUR;
                        busy       <= 1'b1;
                        armed      <= 1'b0;
                    end
                end
                DRAW: begin
                    armed <= 1'b1;
                    if (armed && cnt_done) begin
                        state      <= WAIT;
                        cnt_enable <= 1'b0;
                        plot       <= 1'b0;
                    end
                end
                WAIT: begin
                    if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            if (go) begin
                                state      <= ERASE;
                                cnt_enable <= 1'b1;
                                plot       <= 1'b1;
                                colour     <= BG_COLOUR;
                                armed      <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                ERASE: begin
                    armed <= 1'b1;
                    if (armed && cnt_done) begin
                        state      <= UPDATE;
                        cnt_enable <= 1'b0;
                        plot       <= 1'b0;
                    end
                end
                UPDATE: begin
                    x_org      <= x_next;
                    y_org      <= y_next;
                    state      <= DRAW;
                    cnt_enable <= 1'b1;
                    plot       <= 1'b1;
                    colour     <= FG_COLOUR;
                    armed      <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cnt_enable <= 1'b0;
                    plot       <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Randomized scoreboard bench for sprite_move_ctrl: a step-level origin model predicts every
// draw/erase box and every return to idle; a monitor compares them as the DUT produces them.
module tb_sprite_move_ctrl;

    localparam int XMAX = 312;
    localparam int YMAX = 232;
    localparam int X0   = 10;
    localparam int Y0   = 20;
    localparam int FPS  = 2;
    localparam int FG   = 7;
    localparam int BG   = 0;
    localparam int K_DRAW  = 0;
    localparam int K_ERASE = 1;
    localparam int K_IDLE  = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int dur;
    } exp_t;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b1;
    logic       go         = 1'b0;
    logic       frame_tick = 1'b0;
    logic       dir_left   = 1'b0;
    logic       dir_right  = 1'b0;
    logic       dir_up     = 1'b0;
    logic       dir_down   = 1'b0;
    logic       cnt_done   = 1'b1;
    logic       cnt_enable;
    logic [8:0] x_org;
    logic [7:0] y_org;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   len_q[$];
    int   mx = X0;
    int   my = Y0;
    bit   mon_en = 1'b0;

    sprite_move_ctrl #(
        .X_START        (9'd10),
        .Y_START        (8'd20),
        .X_MAX_POS      (9'd312),
        .Y_MAX_POS      (8'd232),
        .FRAMES_PER_STEP(FPS),
        .FG_COLOUR      (3'b111),
        .BG_COLOUR      (3'b000)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .go        (go),
        .frame_tick(frame_tick),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .cnt_done  (cnt_done),
        .cnt_enable(cnt_enable),
        .x_org     (x_org),
        .y_org     (y_org),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Box counter model: done is registered, clears with the index only once enabled, and holds while idle.
    int idx = 0;
    int cur_len = 4;

    function automatic int head_len();
        return (len_q.size() > 0) ? len_q[0] : 4;
    endfunction

    always @(posedge clock) begin
        if (!cnt_enable) begin
            idx <= 0;
        end else begin
            idx <= idx + 1;
            if (idx == 0) begin
                cur_len  <= head_len();
                cnt_done <= (head_len() <= 1);
                if (len_q.size() > 0) void'(len_q.pop_front());
            end else begin
                cnt_done <= (idx + 1 >= cur_len);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, want %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    endtask

    task automatic fail_timeout(input string what);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL timeout_%s: condition not reached within cycle budget", what);
        finish_run();
    endtask

    function automatic int step_axis(input int p, input bit neg, input bit pos, input int maxv);
        int d;
        int n;
        d = (pos && !neg) ? 1 : ((neg && !pos) ? -1 : 0);
        n = p + d;
`ifdef SPRITE_WRAP_EN
        if (n < 0) n = maxv;
        else if (n > maxv) n = 0;
`else
        if (n < 0) n = 0;
        else if (n > maxv) n = maxv;
`endif
        return n;
    endfunction

    function automatic void push_exp(input int kind, input int x, input int y, input int dur);
        exp_t e;
        e.kind = kind;
        e.x    = x;
        e.y    = y;
        e.dur  = dur;
        exp_q.push_back(e);
    endfunction

    // Waits for cnt_enable to reach a level; frame_tick noise here lands outside WAIT and must be ignored.
    task automatic wait_en(input logic level, input string what);
        for (int i = 0; i < 400; i++) begin
            if (cnt_enable === level) begin
                frame_tick = 1'b0;
                return;
            end
            frame_tick = ($urandom_range(0, 3) == 0);
            @(negedge clock);
        end
        frame_tick = 1'b0;
        fail_timeout(what);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b0) return;
            @(negedge clock);
        end
        fail_timeout("idle");
    endtask

    // One move step, entered with the DUT in WAIT right after a draw box.
    task automatic applyStimulus(input bit go_final, input bit l, input bit r, input bit u, input bit d,
                                 input int le, input int ld);
        dir_left  = l;
        dir_right = r;
        dir_up    = u;
        dir_down  = d;
        for (int t = 0; t < FPS; t++) begin
            repeat ($urandom_range(0, 2)) begin
                go = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            go = (t == FPS - 1) ? go_final : 1'($urandom_range(0, 1));
            frame_tick = 1'b1;
            if (t == FPS - 1) begin
                if (go_final) begin
                    push_exp(K_ERASE, mx, my, le + 1);
                    len_q.push_back(le);
                    mx = step_axis(mx, l, r, XMAX);
                    my = step_axis(my, u, d, YMAX);
                    push_exp(K_DRAW, mx, my, ld + 1);
                    len_q.push_back(ld);
                end else begin
                    push_exp(K_IDLE, mx, my, 0);
                end
            end
            @(negedge clock);
            frame_tick = 1'b0;
        end
        if (go_final) begin
            wait_en(1'b1, "erase_start");
            wait_en(1'b0, "erase_end");
            wait_en(1'b1, "draw_start");
            wait_en(1'b0, "draw_end");
        end else begin
            wait_idle();
            repeat ($urandom_range(1, 4)) begin
                frame_tick = ($urandom_range(0, 1) == 0);
                @(negedge clock);
            end
            frame_tick = 1'b0;
            go = 1'b1;
            push_exp(K_DRAW, mx, my, ld + 1);
            len_q.push_back(ld);
            wait_en(1'b1, "redraw_start");
            wait_en(1'b0, "redraw_end");
        end
    endtask

    // Monitor: pops one expectation per box start and per return to idle.
    exp_t cur;
    logic prev_en   = 1'b0;
    logic prev_busy = 1'b0;
    int   run_len   = 0;
    int   gap_len   = 0;
    int   last_kind = K_IDLE;

    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && resetn) begin
                if (cnt_enable && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("box_unexpected", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.kind == K_IDLE) begin
                            checkOutput("box_instead_of_idle", 1, 0);
                        end else begin
                            checkOutput(cur.kind == K_DRAW ? "draw_colour" : "erase_colour",
                                        int'(colour), cur.kind == K_DRAW ? FG : BG);
                            checkOutput("box_x", int'(x_org), cur.x);
                            checkOutput("box_y", int'(y_org), cur.y);
                            checkOutput("box_plot", int'(plot), 1);
                            checkOutput("box_busy", int'(busy), 1);
                            if (cur.kind == K_DRAW && last_kind == K_ERASE)
                                checkOutput("update_gap", gap_len, 1);
                        end
                        last_kind = cur.kind;
                    end
                    run_len = 1;
                end else if (cnt_enable) begin
                    run_len++;
                end
                if (!cnt_enable && prev_en) begin
                    checkOutput("box_len", run_len, cur.dur);
                    checkOutput("box_x_stable", int'(x_org), cur.x);
                    checkOutput("box_y_stable", int'(y_org), cur.y);
                    checkOutput("plot_off", int'(plot), 0);
                end
                if (!busy && prev_busy) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("idle_unexpected", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        checkOutput("idle_kind", cur.kind, K_IDLE);
                        checkOutput("idle_x", int'(x_org), cur.x);
                        checkOutput("idle_y", int'(y_org), cur.y);
                        last_kind = K_IDLE;
                    end
                end
                if (cnt_enable) gap_len = 0;
                else gap_len++;
            end
            prev_en   = cnt_enable;
            prev_busy = busy;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        n_errors++;
        finish_run();
    end

    initial begin
        bit gf;
        #2 resetn = 1'b0;
        #1;
        checkOutput("reset_x", int'(x_org), X0);
        checkOutput("reset_y", int'(y_org), Y0);
        checkOutput("reset_plot", int'(plot), 0);
        checkOutput("reset_enable", int'(cnt_enable), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_colour", int'(colour), BG);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        // First box: long counter run, with done left high from a previous run.
        go = 1'b1;
        push_exp(K_DRAW, mx, my, 81);
        len_q.push_back(80);
        wait_en(1'b1, "first_draw_start");
        wait_en(1'b0, "first_draw_end");

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 4);

        for (int s = 0; s < 30; s++) begin
            gf = ($urandom_range(0, 3) != 0);
            applyStimulus(gf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
        end

        for (int s = 0; s < 330 && !(mx == XMAX && my == YMAX); s++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2);

        for (int s = 0; s < 330 && !(mx == 0 && my == 0); s++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2);

        for (int s = 0; s < 15; s++) begin
            gf = ($urandom_range(0, 3) != 0);
            applyStimulus(gf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
        end
        checkOutput("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a draw box.
        mon_en = 1'b0;
        len_q.push_back(2);
        len_q.push_back(60);
        go = 1'b1;
        for (int t = 0; t < FPS; t++) begin
            frame_tick = 1'b1;
            @(negedge clock);
            frame_tick = 1'b0;
            @(negedge clock);
        end
        wait_en(1'b0, "final_erase_end");
        wait_en(1'b1, "final_draw_start");
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checkOutput("midreset_x", int'(x_org), X0);
        checkOutput("midreset_y", int'(y_org), Y0);
        checkOutput("midreset_plot", int'(plot), 0);
        checkOutput("midreset_enable", int'(cnt_enable), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_colour", int'(colour), BG);
        finish_run();
    end

endmodule
